// File: rtl/noc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo_pkg
// Description : Shared constants, output-buffer occupancy encoding and the
//               pointer-distance helper used by both sides of the 32 x 64-bit
//               NoC FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_fifo_pkg;

    localparam int DATA_W = 64;          // flit width
    localparam int DEPTH  = 32;          // storage entries (power of two)
    localparam int ADDR_W = 5;           // log2(DEPTH)
    localparam int PTR_W  = ADDR_W + 1;  // MSB is the wrap bit

    // Occupancy of the two-register output buffer (head + skid).
    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_t;

    // Distance from tail to head pointer modulo 2^PTR_W. With the extra wrap
    // bit this yields 0..DEPTH for a healthy FIFO; anything larger means the
    // pointers have drifted apart.
    function automatic logic [PTR_W-1:0] ptr_dist(
        input logic [PTR_W-1:0] head,
        input logic [PTR_W-1:0] tail
    );
        return head - tail;
    endfunction

endpackage
`default_nettype wire

// File: rtl/noc_fifo_skid.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo_skid
// Description : Two-entry registered output buffer (head + skid) feeding a
//               valid/ready interface. Head drives m_data; skid absorbs the
//               word popped in the cycle a stall is first seen, so upstream
//               reads never need to look at m_ready combinationally to
//               decide what to present downstream.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               push, push_data   - word popped from storage this cycle
//               can_push          - buffer can accept a word this cycle
//               m_valid, m_data   - registered output word
//               m_ready           - downstream accepts m_data
// Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo_skid #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              can_push,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);
    import noc_fifo_pkg::*;

    occ_t              r_occ;
    occ_t              w_occ_nxt;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_head_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_deq;

    assign m_valid = (r_occ != OCC0);
    assign m_data  = r_head;
    assign w_deq   = m_valid & m_ready;

    // When full, a slot only frees up if the head leaves this cycle.
    assign can_push = (r_occ != OCC2) | m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= OCC0;
            r_head <= '0;
            r_skid <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_head <= w_head_nxt;
            r_skid <= w_skid_nxt;
        end
    end

    always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        case (r_occ)
            OCC0: begin
                if (push) begin
                    w_head_nxt = push_data;
                    w_occ_nxt  = OCC1;
                end
            end
            OCC1: begin
                if (push && w_deq) begin
                    w_head_nxt = push_data;
                end else if (push) begin
                    w_skid_nxt = push_data;
                    w_occ_nxt  = OCC2;
                end else if (w_deq) begin
                    w_occ_nxt  = OCC0;
                end
            end
            OCC2: begin
                // Skid is older than anything still in storage, so it
                // always advances to head before a new word lands in skid.
                if (w_deq) begin
                    w_head_nxt = r_skid;
                    if (push) begin
                        w_skid_nxt = push_data;
                    end else begin
                        w_occ_nxt  = OCC1;
                    end
                end
            end
            default: begin
                w_occ_nxt = OCC0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/noc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : noc_fifo_reader
// Description : Read side of the 32-entry x 64-bit NoC FIFO. Owns the read
//               pointer, empty/occupancy detection and a sticky pointer
//               error flag, drives the storage read address and drains words
//               into a registered valid/ready output buffer.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               wr_ptr            - write pointer from the write side
//               rd_addr, rd_data  - storage read port (combinational data)
//               rd_ptr            - read pointer, exported for full detect
//               empty, count      - storage empty flag and occupancy
//               m_valid, m_data,
//               m_ready           - output stream toward the crossbar
//               ptr_err           - sticky, occupancy exceeded DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module noc_fifo_reader #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int PTR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PTR_W-1:0]  wr_ptr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [PTR_W-1:0]  rd_ptr,
    output logic              empty,
    output logic [PTR_W-1:0]  count,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              ptr_err
);
    import noc_fifo_pkg::*;

    localparam logic [PTR_W-1:0] c_depth = PTR_W'(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_ptr_err;
    logic [PTR_W-1:0] w_count;
    logic             w_empty;
    logic             w_can_push;
    logic             w_pop;

    // Both flags derive from registered pointers only.
    assign w_count = ptr_dist(wr_ptr, r_rd_ptr);
    assign w_empty = (wr_ptr == r_rd_ptr);

    // m_ready reaches the pop decision only through can_push; it affects
    // the read pointer register, never m_valid/m_data directly.
    assign w_pop = ~w_empty & w_can_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr  <= '0;
            r_ptr_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_count > c_depth) begin
                r_ptr_err <= 1'b1;
            end
        end
    end

    noc_fifo_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (w_pop),
        .push_data (rd_data),
        .can_push  (w_can_push),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready)
    );

    assign rd_ptr  = r_rd_ptr;
    assign rd_addr = r_rd_ptr[ADDR_W-1:0];
    assign empty   = w_empty;
    assign count   = w_count;
    assign ptr_err = r_ptr_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_fifo_reader
// Description : Self-checking bench for noc_fifo_reader. The bench owns the
//               storage array and the write pointer, and keeps a word-level
//               model: a queue of every word not yet delivered, the number of
//               words in storage and the number held in the output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_fifo_reader;

    logic        clk;
    logic        reset;
    logic [5:0]  wr_ptr;
    logic [4:0]  rd_addr;
    logic [63:0] rd_data;
    logic [5:0]  rd_ptr;
    logic        empty;
    logic [5:0]  count;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_ready;
    logic        ptr_err;

    logic [63:0] mem [32];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [63:0] q[$];     // words written and not yet delivered, oldest first
    int          ms;       // words in storage
    int          mb;       // words in output buffer
    logic [5:0]  wp;       // write pointer
    logic [5:0]  m_rdp;    // expected read pointer

    assign rd_data = mem[rd_addr];

    noc_fifo_reader dut (
        .clk     (clk),
        .reset   (reset),
        .wr_ptr  (wr_ptr),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_ptr  (rd_ptr),
        .empty   (empty),
        .count   (count),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .ptr_err (ptr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear();
        q.delete();
        ms    = 0;
        mb    = 0;
        m_rdp = '0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_ready = 1'b0;
        wp      = '0;
        wr_ptr  = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One clock cycle: optional write into storage, drive m_ready, advance.
    // The buffer takes a new word whenever storage has one and it either has
    // room or its head leaves this cycle.
    task automatic step(input logic ready, input logic wr, input logic [63:0] wdata);
        bit deq;
        bit pop;
        m_ready = ready;
        if (wr) begin
            mem[wp[4:0]] = wdata;
            wp     = wp + 6'd1;
            wr_ptr = wp;
            ms++;
            q.push_back(wdata);
        end
        deq = (mb > 0) && ready;
        pop = (ms > 0) && ((mb < 2) || deq);
        @(posedge clk); #1;
        if (deq) void'(q.pop_front());
        mb = mb - int'(deq) + int'(pop);
        ms = ms - int'(pop);
        if (pop) m_rdp = m_rdp + 6'd1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        n_tests++; if (rd_ptr !== 6'd0) begin n_fail++; $display("FAIL reset_rd_ptr: got %0d expected 0", rd_ptr); end
        n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_tests++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (ptr_err !== 1'b0) begin n_fail++; $display("FAIL reset_ptr_err: got %b expected 0", ptr_err); end
    endtask

    task automatic test_latency();
        do_reset();
        step(1'b1, 1'b1, 64'hA5A5_0000_0000_0001);
        n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b expected 1", m_valid); end
        n_tests++; if (m_data !== 64'hA5A5_0000_0000_0001) begin n_fail++; $display("FAIL latency_data: got %h expected a5a5000000000001", m_data); end
        n_tests++; if (rd_ptr !== 6'd1) begin n_fail++; $display("FAIL latency_rd_ptr: got %0d expected 1", rd_ptr); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL latency_empty: got %b expected 1", empty); end
        step(1'b1, 1'b0, 64'd0);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL latency_drained: got %b expected 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            w = {32'hB0B0_0000, 32'(i)};
            step(1'b1, 1'b1, w);
            n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, m_valid); end
            n_tests++; if (m_data !== w) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, m_data, w); end
        end
        n_tests++; if (rd_ptr !== 6'd32) begin n_fail++; $display("FAIL b2b_rd_ptr: got %0d expected 32", rd_ptr); end
        n_tests++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL b2b_rd_addr: got %0d expected 0", rd_addr); end
        step(1'b1, 1'b0, 64'd0);
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b expected 0", m_valid); end
    endtask

    task automatic test_stall();
        logic [63:0] w;
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, {32'hC0DE_0000, 32'(i)});
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 64'd0);
        n_tests++; if (rd_ptr !== 6'd2) begin n_fail++; $display("FAIL stall_rd_ptr: got %0d expected 2", rd_ptr); end
        n_tests++; if (count !== 6'd30) begin n_fail++; $display("FAIL stall_count: got %0d expected 30", count); end
        for (int i = 0; i < 32; i++) begin
            w = {32'hC0DE_0000, 32'(i)};
            n_tests++; if (m_valid !== 1'b1 || m_data !== w) begin n_fail++; $display("FAIL stall_release[%0d]: got v=%b %h expected v=1 %h", i, m_valid, m_data, w); end
            step(1'b1, 1'b0, 64'd0);
        end
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b expected 0", m_valid); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stall_empty: got %b expected 1", empty); end
    endtask

    task automatic test_random();
        int   written = 0;
        int   cyc     = 0;
        logic rdy;
        logic wr;
        do_reset();
        while ((written < 200 || q.size() > 0) && cyc < 3000) begin
            rdy = 1'($urandom_range(0, 1));
            wr  = (written < 200) && (ms < 32) && ($urandom_range(0, 3) != 0);
            step(rdy, wr, {$urandom, $urandom});
            if (wr) written++;
            cyc++;
            n_tests++; if (m_valid !== (mb > 0)) begin n_fail++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, m_valid, (mb > 0)); end
            if (mb > 0) begin
                n_tests++; if (m_data !== q[0]) begin n_fail++; $display("FAIL rand_data@%0d: got %h expected %h", cyc, m_data, q[0]); end
            end
            n_tests++; if (rd_ptr !== m_rdp) begin n_fail++; $display("FAIL rand_rd_ptr@%0d: got %0d expected %0d", cyc, rd_ptr, m_rdp); end
            n_tests++; if (count !== 6'(ms)) begin n_fail++; $display("FAIL rand_count@%0d: got %0d expected %0d", cyc, count, ms); end
            n_tests++; if (ptr_err !== 1'b0) begin n_fail++; $display("FAIL rand_ptr_err@%0d: got %b expected 0", cyc, ptr_err); end
        end
        n_tests++; if (cyc >= 3000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles expected < 3000", cyc); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, {32'hD00D_0000, 32'(i)});
        n_tests++; if (count !== 6'd5 || m_valid !== 1'b1) begin n_fail++; $display("FAIL midop_setup: got count=%0d v=%b expected count=5 v=1", count, m_valid); end
        reset  = 1'b1;
        wp     = '0;
        wr_ptr = '0;
        @(posedge clk); #1;
        n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midop_valid: got %b expected 0", m_valid); end
        n_tests++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL midop_data: got %h expected 0", m_data); end
        n_tests++; if (rd_ptr !== 6'd0) begin n_fail++; $display("FAIL midop_rd_ptr: got %0d expected 0", rd_ptr); end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midop_empty: got %b expected 1", empty); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_ptr_err();
        do_reset();
        wr_ptr = 6'd33;
        #1;
        n_tests++; if (ptr_err !== 1'b0) begin n_fail++; $display("FAIL ptr_err_pre: got %b expected 0", ptr_err); end
        @(posedge clk); #1;
        n_tests++; if (ptr_err !== 1'b1) begin n_fail++; $display("FAIL ptr_err_rise: got %b expected 1", ptr_err); end
        wr_ptr = rd_ptr;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_tests++; if (ptr_err !== 1'b1) begin n_fail++; $display("FAIL ptr_err_sticky[%0d]: got %b expected 1", i, ptr_err); end
        end
        do_reset();
        n_tests++; if (ptr_err !== 1'b0) begin n_fail++; $display("FAIL ptr_err_cleared: got %b expected 0", ptr_err); end
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        wr_ptr  = '0;
        m_ready = 1'b0;
        wp      = '0;
        model_clear();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midop();
        test_ptr_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_fifo_reader.md
# noc_fifo_reader

Read side of the 32-entry × 64-bit NoC FIFO. Owns the read pointer and empty/occupancy detection. Drives the read address of the FIFO storage array and drains words into a registered valid/ready output toward the router crossbar. Pairs with the write-side logic, which owns the write pointer and full detection and consumes `rd_ptr` from this block.

## Interface
Parameters:
- `DATA_W`, 64, flit width
- `DEPTH`, 32, storage entries (power of two)
- `ADDR_W`, 5, log2(DEPTH)
- `PTR_W`, 6, ADDR_W+1 (MSB is the wrap bit)

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `wr_ptr`  in  PTR_W  write pointer from the write side, same clock domain; points to the next free entry
- `rd_addr`  out  ADDR_W  storage read address, equal to `rd_ptr[ADDR_W-1:0]`
- `rd_data`  in  DATA_W  combinational storage read data at `rd_addr`
- `rd_ptr`  out  PTR_W  read pointer, exported to the write side for full detection
- `empty`  out  1  storage holds no unread words
- `count`  out  PTR_W  storage occupancy, 0..DEPTH
- `m_valid`  out  1  output word valid
- `m_data`  out  DATA_W  output word
- `m_ready`  in  1  downstream accepts word
- `ptr_err`  out  1  sticky; occupancy exceeded DEPTH

## Operation
- `empty = (rd_ptr == wr_ptr)`.
- `count = (wr_ptr - rd_ptr) mod 2^PTR_W`. Both are combinational from registered pointers.
- Output buffer: two registers, head (drives `m_data`) and skid. Occupancy `occ` ∈ {OCC0, OCC1, OCC2}, `m_valid = (occ != OCC0)`.
- `deq = m_valid & m_ready`.
- `pop = !empty & (occ == OCC0 | occ == OCC1 | (occ == OCC2 & deq))`.
- On `pop`:
  - capture `rd_data` into the buffer;
  - `rd_ptr <= rd_ptr + 1`, wrapping mod 2^PTR_W. Entry 31 → entry 0 and the wrap bit toggles.
- Buffer transitions:
  - OCC0 + pop → OCC1; popped word goes to head.
  - OCC1 + pop, no deq → OCC2; popped word goes to skid.
  - OCC1 + pop + deq → OCC1; popped word goes to head.
  - OCC1 + deq, no pop → OCC0.
  - OCC2 + deq (pop implied if !empty) → skid moves to head, popped word goes to skid; occ stays OCC2. If empty: skid moves to head → OCC1.
  - OCC2, no deq → hold, no pop.
- Ordering is strictly FIFO. Head is always older than skid, and skid is older than storage.
- `m_data` is stable while `m_valid & !m_ready`.
- `ptr_err` sets when `count > DEPTH` and clears only on reset. Block behaviour after `ptr_err` is don't-care.

## Timing
- Reset values: `rd_ptr = 0`, `rd_addr = 0`, occ = OCC0, `m_valid = 0`, `m_data = 0`, skid = 0, `ptr_err = 0`. `empty`/`count` follow from `wr_ptr`.
- Reset mid-operation discards both buffered words. The write side must be reset in the same cycle.
- Latency: a word written at edge E0 (wr_ptr advances at E0) is popped in the cycle after E0 and appears with `m_valid = 1` after edge E1. One cycle, write to output.
- Throughput: with `m_ready` held high, one word per cycle sustained. No bubble on a downstream stall or on release.
- `m_ready` low for any number of cycles: at most 2 words leave storage; `rd_ptr` then freezes.
- Storage empty while buffer is non-empty: output continues draining, no pop.
- Write and pop in the same cycle: `count` is unchanged next cycle. Storage must not be overwritten at `rd_addr` in that cycle; the write side's full check guarantees this.
- Full storage (`count = 32`): pop is allowed normally. `rd_ptr` advance frees the entry on the next cycle.
- No combinational path from `m_ready` to `m_valid` or `m_data`. `m_ready` → `rd_ptr` is registered.

## Structure
- Shared package `noc_fifo_pkg`:
  - `DATA_W`, `DEPTH`, `ADDR_W`, `PTR_W` constants;
  - `occ_t` enum {OCC0, OCC1, OCC2};
  - pointer-distance function used by both FIFO sides.
- Sub-module `noc_fifo_skid`: 2-entry output buffer with the occ state machine. Inputs `push`/`push_data`; outputs `m_valid`, `m_data`, `can_push`.
- Top level: pointers, empty/count, `ptr_err`, and the pop decision.

## Test plan
- Reset, then one write (`wr_ptr` 0→1, `rd_data` = 0xA5A5_0000_0000_0001) with `m_ready = 1` → `m_valid` high exactly one cycle after the write edge, data matches; `rd_ptr = 1`, `empty = 1`.
- 32 back-to-back writes 0..31 with `m_ready = 1` → 32 consecutive output beats in order, no gaps; `rd_ptr` ends at 32 (wrap bit set, `rd_addr = 0`).
- Storage pre-filled with 32 words, `m_ready = 0` for 10 cycles → `rd_ptr = 2`, `count = 30`, `m_data` holds word 0. Release → words 0..31 in order, one per cycle.
- Random `m_ready` (50%) over 200 words spanning 6 pointer wraps → scoreboard order exact, never more than 2 words in flight, `ptr_err = 0`.
- Reset asserted while occ = OCC2 and `count = 5` (writer reset too) → next cycle `m_valid = 0`, `m_data = 0`, `rd_ptr = 0`, `empty = 1`.
- Force `wr_ptr = rd_ptr + 33` → `ptr_err` rises the next cycle and stays high until reset.
